// File: rtl/seg_decoder_checker.sv
// seg_decoder_checker: samples a seven-segment pattern on each slow_clk rising edge, decodes it to hex,
// flags illegal patterns and (with SEQ_CHECK_EN defined) flags values that are not previous+1 mod 16.
// Ports: clk/reset (sync, active-high), slow_clk async strobe, seg {g..a} active-high;
// val/val_valid decoded value and its pulse, bad_code and seq_err pulses, err_count saturating error count.
module seg_decoder_checker #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic [6:0]       seg,
  output logic [3:0]       val,
  output logic             val_valid,
  output logic             bad_code,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);
  localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, DECODE} state_t;
  state_t state_q, state_d;
  logic slow_meta_q, slow_sync_q, slow_prev_q;
  logic [6:0] seg_meta_q, seg_sync_q;
  logic [6:0] latch_q, latch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] val_q, val_d;
  logic val_valid_q, val_valid_d, bad_code_q, bad_code_d, seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic dec_ok;
  logic [3:0] dec_val;
  logic rise;
`ifdef SEQ_CHECK_EN
  logic [3:0] prev_q, prev_d;
  logic have_prev_q, have_prev_d;
`endif
  // synchronizers run free through reset so a strobe held across reset is not seen as a fresh edge
  always_ff @(posedge clk) begin
    slow_meta_q <= slow_clk;
    slow_sync_q <= slow_meta_q;
    slow_prev_q <= slow_sync_q;
    seg_meta_q  <= seg;
    seg_sync_q  <= seg_meta_q;
  end
  assign rise = slow_sync_q & ~slow_prev_q;
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (latch_q)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d     = state_q;
    latch_d     = latch_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    val_valid_d = 1'b0;
    bad_code_d  = 1'b0;
    seq_err_d   = 1'b0;
`ifdef SEQ_CHECK_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
`endif
    case (state_q)
      IDLE: if (rise) begin
        latch_d = seg_sync_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: if (seg_sync_q != latch_q) begin
        latch_d = seg_sync_q;
        cnt_d   = '0;
      end else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = DECODE;
      else cnt_d = cnt_q + 1'b1;
      DECODE: begin
        state_d     = IDLE;
        val_valid_d = dec_ok;
        bad_code_d  = ~dec_ok;
        val_d       = dec_ok ? dec_val : val_q;
`ifdef SEQ_CHECK_EN
        seq_err_d   = dec_ok && have_prev_q && (dec_val != 4'(prev_q + 4'd1));
        prev_d      = dec_ok ? dec_val : prev_q;
        have_prev_d = have_prev_q | dec_ok;
`endif
      end
      default: state_d = IDLE;
    endcase
    err_count_d = (bad_code_d || seq_err_d) && (err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      latch_q     <= '0;
      cnt_q       <= '0;
      val_q       <= '0;
      val_valid_q <= 1'b0;
      bad_code_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
`ifdef SEQ_CHECK_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      val_valid_q <= val_valid_d;
      bad_code_q  <= bad_code_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
`ifdef SEQ_CHECK_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
`endif
    end
  end
  assign val       = val_q;
  assign val_valid = val_valid_q;
  assign bad_code  = bad_code_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
endmodule

// File: doc/seg_decoder_checker.md
Name: seg_decoder_checker

Overview:
Receive-side block for the counter's seven-segment output. It samples a segment pattern on each strobe edge, decodes it back to a 4-bit hex value, flags illegal patterns and, optionally, checks that consecutive values increment by one. It sits on the checker/self-test side of the display path and runs on the fast system clock; the strobe is asynchronous to it.

Parameters:
STABLE_CYCLES, 4, consecutive clk cycles the synchronized seg must hold unchanged before decode (legal values are 1 and above)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
slow_clk  input  1  asynchronous sample strobe; the rising edge requests a capture
seg  input  7  segment pattern {g,f,e,d,c,b,a}, active-high (1 = lit)
val  output  4  last successfully decoded hex value
val_valid  output  1  one-cycle pulse when val updates
bad_code  output  1  one-cycle pulse when the settled pattern is not a legal digit
seq_err  output  1  one-cycle pulse when the decoded value is not the previous value + 1 (mod 16)
err_count  output  ERR_W  saturating count of bad_code and seq_err events

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high.
- Synchronization: slow_clk and seg each pass through a 2-flop synchronizer. A rising edge is sync2 high while the previous sync2 was low.
- Reset values: all outputs are 0. The FSM goes to IDLE, the settle counter and seg latch clear, and have_prev is cleared. Reset takes effect in any state, including mid-SETTLE; the capture in progress is dropped and no pulse is issued.
- FSM states: IDLE, SETTLE, DECODE.
  - IDLE: on a detected rising edge, latch the synchronized seg, clear the counter and go to SETTLE.
  - SETTLE: if synchronized seg differs from the latch, re-latch it and clear the counter. Otherwise increment the counter. When the counter reaches STABLE_CYCLES-1 with no change, go to DECODE. Further slow_clk edges seen in SETTLE or DECODE are ignored and not queued.
  - DECODE: one cycle. Register the results and return to IDLE.
- Timing: with seg stable, val_valid or bad_code is high exactly STABLE_CYCLES+3 clk cycles after the first clk edge that samples slow_clk high. With the default that is 7 cycles.
- Decode table (seg hex -> value):
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7
  - 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F
  - Any other pattern is illegal.
- Legal pattern: val takes the new value and val_valid pulses.
- Illegal pattern: bad_code pulses, val holds its old value, val_valid stays 0, and prev is not updated.
- Sequence check (macro-enabled only):
  - The first legal decode after reset sets prev and have_prev and never raises seq_err.
  - For each later legal decode, seq_err pulses in the same cycle as val_valid if the value is not (prev+1) mod 16. F followed by 0 is legal.
  - prev always updates to the new value, even when seq_err fires.
- err_count: increments by 1 on any cycle where bad_code or seq_err is high; the two cannot both be high in one cycle. It saturates at 2^ERR_W-1 and does not wrap.

Optional Feature:
SEQ_CHECK_EN:
- Defined: sequence checker is present and behaves as described above.
- Undefined: prev/have_prev logic is removed, seq_err is tied to 0, and err_count counts bad_code only. All other timing is unchanged.

Test Plan:
1. Reset 2 cycles, seg=0x3F, slow_clk high 10 cycles -> val_valid pulses 7 cycles after the first sampled high, val=0, bad_code=0, seq_err=0, err_count=0.
2. Present 0x3F,0x06,0x5B,…,0x71, then 0x3F again, one per slow_clk pulse -> 17 val_valid pulses with val 0..F then 0; seq_err never asserts (wrap F->0 accepted); err_count=0.
3. After val=3, present seg=0x00 -> bad_code pulses, val stays 3, val_valid=0, err_count=1. Then present 0x66 -> val=4 with no seq_err.
4. (SEQ_CHECK_EN) Decode 3, then 0x6D -> val=5, val_valid and seq_err pulse together, err_count increments. Then 0x7D -> val=6, no seq_err.
5. Strobe with seg=0x06, change seg to 0x5B 2 cycles into SETTLE -> decode is delayed by the restart, val=2, a single val_valid; a second strobe during SETTLE produces no extra pulse.
6. Reset asserted mid-SETTLE -> all outputs 0 next cycle, no pulse for the aborted capture; the next strobe with 0x4F gives val=3 with no seq_err. With ERR_W=2, four bad codes -> err_count stays 3.
